// File: rtl/tag_array_arbiter.sv
// Arbiter for a single-port cache tag array: flush sequencer, refill writes, core lookups.
// Defining TAG_ARB_STARVE_EN adds a core anti-starvation override after STARVE_LIMIT losses.
module tag_array_arbiter #(
  parameter int unsigned SETS         = 64,
  parameter int unsigned WAYS         = 4,
  parameter int unsigned TAG_WIDTH    = 20,
  parameter int unsigned ADDR_WIDTH   = $clog2(SETS),
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        core_req_valid,
  output logic                        core_req_ready,
  input  logic [ADDR_WIDTH-1:0]       core_req_idx,
  output logic                        core_resp_valid,
  output logic [WAYS*TAG_WIDTH-1:0]   core_resp_tag,
  input  logic                        refill_req_valid,
  output logic                        refill_req_ready,
  input  logic [ADDR_WIDTH-1:0]       refill_req_idx,
  input  logic [WAYS-1:0]             refill_req_way,
  input  logic [TAG_WIDTH-1:0]        refill_req_tag,
  input  logic                        flush_req,
  output logic                        flush_busy,
  output logic                        mem_wen,
  output logic [ADDR_WIDTH-1:0]       mem_waddr,
  output logic [WAYS-1:0]             mem_cs,
  output logic [WAYS*TAG_WIDTH-1:0]   mem_wdata,
  output logic                        mem_ren,
  output logic [ADDR_WIDTH-1:0]       mem_raddr,
  input  logic [WAYS*TAG_WIDTH-1:0]   mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_SET = ADDR_WIDTH'(SETS - 1);

  typedef enum logic {ST_FLUSH, ST_IDLE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] flush_cnt;
  logic                  resp_q;
  logic                  flushing;
  logic                  flush_go;
  logic                  refill_gnt;
  logic                  core_gnt;
  logic                  core_force;

`ifdef TAG_ARB_STARVE_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;

  assign core_force = (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // Consecutive IDLE cycles in which a waiting core lost to refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (core_gnt || flush_go) begin
        starve_cnt <= '0;
      end else if (core_req_valid && refill_gnt && !core_force) begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end
`else
  logic unused_starve_limit;

  assign core_force          = 1'b0;
  assign unused_starve_limit = ^STARVE_LIMIT;
`endif

  assign flushing = !reset && (state == ST_FLUSH);

  // IDLE arbitration: flush request, then refill, then core.
  always_comb begin
    flush_go   = 1'b0;
    refill_gnt = 1'b0;
    core_gnt   = 1'b0;
    if (!reset && state == ST_IDLE) begin
      if (flush_req) begin
        flush_go = 1'b1;
      end else if (refill_req_valid && !(core_force && core_req_valid)) begin
        refill_gnt = 1'b1;
      end else if (core_req_valid) begin
        core_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    flush_busy       = flushing;
    refill_req_ready = refill_gnt;
    core_req_ready   = core_gnt;
    mem_wen          = 1'b0;
    mem_waddr        = '0;
    mem_cs           = '0;
    mem_wdata        = '0;
    mem_ren          = 1'b0;
    mem_raddr        = '0;
    if (flushing) begin
      mem_wen   = 1'b1;
      mem_waddr = flush_cnt;
      mem_cs    = '1;
    end else if (refill_gnt) begin
      mem_wen   = 1'b1;
      mem_waddr = refill_req_idx;
      mem_cs    = refill_req_way;
      mem_wdata = {WAYS{refill_req_tag}};
    end
    if (core_gnt) begin
      mem_ren   = 1'b1;
      mem_raddr = core_req_idx;
    end
  end

  // Response valid is dropped immediately when reset is raised.
  assign core_resp_valid = resp_q && !reset;
  assign core_resp_tag   = core_resp_valid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FLUSH;
      flush_cnt <= '0;
      resp_q    <= 1'b0;
    end else begin
      resp_q <= core_gnt;
      case (state)
        ST_FLUSH: begin
          flush_cnt <= flush_cnt + ADDR_WIDTH'(1);
          if (flush_cnt == LAST_SET) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (flush_go) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tag_array_arbiter.sv
// Self-checking bench for tag_array_arbiter with a behavioural tag-array model and scoreboard.
module tb_tag_array_arbiter;

  localparam int unsigned SETS = 64;
  localparam int unsigned WAYS = 4;
  localparam int unsigned TW   = 20;
  localparam int unsigned AW   = 6;
  localparam int unsigned DW   = WAYS * TW;
  localparam int unsigned STARVE_LIM = 2;
`ifdef TAG_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          core_req_valid, core_req_ready, core_resp_valid;
  logic [AW-1:0] core_req_idx;
  logic [DW-1:0] core_resp_tag;
  logic          refill_req_valid, refill_req_ready;
  logic [AW-1:0] refill_req_idx;
  logic [WAYS-1:0] refill_req_way;
  logic [TW-1:0] refill_req_tag;
  logic          flush_req, flush_busy;
  logic          mem_wen, mem_ren;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [WAYS-1:0] mem_cs;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem_model [SETS];
  logic [TW-1:0] ref_tag [SETS][WAYS];

  tag_array_arbiter #(
    .SETS(SETS), .WAYS(WAYS), .TAG_WIDTH(TW), .ADDR_WIDTH(AW), .STARVE_LIMIT(STARVE_LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_idx(core_req_idx), .core_resp_valid(core_resp_valid),
    .core_resp_tag(core_resp_tag),
    .refill_req_valid(refill_req_valid), .refill_req_ready(refill_req_ready),
    .refill_req_idx(refill_req_idx), .refill_req_way(refill_req_way),
    .refill_req_tag(refill_req_tag),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_cs(mem_cs), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read tag array with per-way write mask.
  always @(posedge clk) begin
    if (mem_wen) begin
      for (int w = 0; w < WAYS; w++) begin
        if (mem_cs[w]) mem_model[mem_waddr][w*TW +: TW] <= mem_wdata[w*TW +: TW];
      end
    end
    if (mem_ren) mem_rdata <= mem_model[mem_raddr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] set_tags(input logic [AW-1:0] s);
    logic [DW-1:0] r;
    for (int w = 0; w < WAYS; w++) r[w*TW +: TW] = ref_tag[s][w];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req_valid   = 1'b0;
    refill_req_valid = 1'b0;
    flush_req        = 1'b0;
  endtask

  task automatic rand_refill();
    refill_req_idx = AW'($urandom_range(0, 7));
    refill_req_way = WAYS'(1 << $urandom_range(0, WAYS - 1));
    refill_req_tag = TW'($urandom);
  endtask

  task automatic clear_ref();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) ref_tag[s][w] = '0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < SETS; s++) mem_model[s] = {$urandom, $urandom, $urandom};
    reset = 1'b1;
    core_req_valid = 1'b1; refill_req_valid = 1'b1; flush_req = 1'b1;
    core_req_idx = 3; rand_refill();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({flush_busy, core_req_ready, refill_req_ready, core_resp_valid, mem_wen, mem_ren,
         mem_waddr, mem_raddr, mem_cs, mem_wdata, core_resp_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b crdy=%b rrdy=%b rv=%b wen=%b ren=%b, required all 0",
               flush_busy, core_req_ready, refill_req_ready, core_resp_valid, mem_wen, mem_ren);
    end
    step();
    reset = 1'b0; flush_req = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      core_req_valid = 1'($urandom); refill_req_valid = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if ({flush_busy, core_req_ready, refill_req_ready, mem_wen, mem_ren, mem_cs, mem_waddr, mem_wdata}
          !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, AW'(i), DW'(0)}) begin
        n_fail++;
        $display("FAIL reset_flush[%0d]: busy=%b crdy=%b rrdy=%b wen=%b ren=%b cs=%h waddr=%0d wdata=%h",
                 i, flush_busy, core_req_ready, refill_req_ready, mem_wen, mem_ren, mem_cs, mem_waddr, mem_wdata);
      end
      step();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({flush_busy, mem_wen} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flush_end: busy=%b wen=%b, required 0 0", flush_busy, mem_wen);
    end
    clear_ref();
    step();
  endtask

  task automatic test_refill_lookup();
    logic [DW-1:0] exp;
    refill_req_valid = 1'b1; refill_req_idx = 5; refill_req_way = 4'b0100; refill_req_tag = 20'hABCDE;
    @(negedge clk);
    n_checks++;
    if ({refill_req_ready, mem_wen, mem_waddr, mem_cs, mem_wdata} !== {1'b1, 1'b1, AW'(5), 4'b0100, {4{20'hABCDE}}}) begin
      n_fail++;
      $display("FAIL refill_grant: rdy=%b wen=%b waddr=%0d cs=%b wdata=%h", refill_req_ready, mem_wen, mem_waddr, mem_cs, mem_wdata);
    end
    ref_tag[5][2] = 20'hABCDE;
    step();
    refill_req_valid = 1'b0; core_req_valid = 1'b1; core_req_idx = 5;
    @(negedge clk);
    n_checks++;
    if ({core_req_ready, mem_ren, mem_raddr, core_resp_valid} !== {1'b1, 1'b1, AW'(5), 1'b0}) begin
      n_fail++;
      $display("FAIL lookup_grant: rdy=%b ren=%b raddr=%0d rv=%b", core_req_ready, mem_ren, mem_raddr, core_resp_valid);
    end
    step();
    core_req_valid = 1'b0;
    exp = DW'(20'hABCDE) << (2 * TW);
    @(negedge clk);
    n_checks++;
    if ({core_resp_valid, core_resp_tag} !== {1'b1, exp}) begin
      n_fail++;
      $display("FAIL lookup_resp: valid=%b tag=%h, required 1 %h", core_resp_valid, core_resp_tag, exp);
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({core_resp_valid, core_resp_tag} !== '0) begin
      n_fail++;
      $display("FAIL lookup_pulse: valid=%b tag=%h, required 0", core_resp_valid, core_resp_tag);
    end
    step();
  endtask

  task automatic test_simultaneous();
    logic          exp_core;
    logic [DW-1:0] exp_tag;
    core_req_valid = 1'b1; core_req_idx = 9; refill_req_valid = 1'b1;
    exp_tag = '0;
    for (int c = 0; c < 3; c++) begin
      rand_refill();
      if (!(STARVE_EN && c == 2)) refill_req_idx = 9;
      @(negedge clk);
      exp_core = STARVE_EN && (c == STARVE_LIM);
      n_checks++;
      if ({core_req_ready, refill_req_ready, mem_ren, mem_wen} !== {exp_core, !exp_core, exp_core, !exp_core}) begin
        n_fail++;
        $display("FAIL simultaneous[%0d]: crdy=%b rrdy=%b, required %b %b", c, core_req_ready, refill_req_ready, exp_core, !exp_core);
      end
      if (!exp_core) begin
        for (int w = 0; w < WAYS; w++) if (refill_req_way[w]) ref_tag[refill_req_idx][w] = refill_req_tag;
      end else begin
        exp_tag = set_tags(9);
      end
      step();
    end
    refill_req_valid = 1'b0;
    if (STARVE_EN) core_req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({core_req_ready, core_resp_valid} !== {!STARVE_EN, STARVE_EN}) begin
      n_fail++;
      $display("FAIL simultaneous_after: crdy=%b rv=%b, required %b %b", core_req_ready, core_resp_valid, !STARVE_EN, STARVE_EN);
    end
    if (!STARVE_EN) exp_tag = set_tags(9);
    step();
    core_req_valid = 1'b0;
    if (!STARVE_EN) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    n_checks++;
    if ({core_resp_valid, core_resp_tag} !== '0) begin
      n_fail++;
      $display("FAIL simultaneous_idle: rv=%b tag=%h, required 0", core_resp_valid, core_resp_tag);
    end
    if (exp_tag !== set_tags(9)) $display("note: set 9 rewritten after lookup");
    step();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp;
    for (int s = 0; s < 3; s++) begin
      refill_req_valid = 1'b1; refill_req_idx = AW'(s);
      refill_req_way = WAYS'(1 << s); refill_req_tag = TW'($urandom);
      ref_tag[s][s] = refill_req_tag;
      step();
    end
    refill_req_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      core_req_valid = (s < 3); core_req_idx = AW'(s);
      @(negedge clk);
      if (s > 0) begin
        exp = exp_q.pop_front();
        n_checks++;
        if ({core_resp_valid, core_resp_tag} !== {1'b1, exp}) begin
          n_fail++;
          $display("FAIL b2b_resp[%0d]: valid=%b tag=%h, required 1 %h", s - 1, core_resp_valid, core_resp_tag, exp);
        end
      end
      if (s < 3) begin
        n_checks++;
        if ({core_req_ready, mem_raddr} !== {1'b1, AW'(s)}) begin
          n_fail++;
          $display("FAIL b2b_grant[%0d]: rdy=%b raddr=%0d", s, core_req_ready, mem_raddr);
        end
        exp_q.push_back(set_tags(AW'(s)));
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic          exp_core, exp_ref, exp_resp, core_done, ref_done;
    logic [DW-1:0] exp_tag;
    int            waits;
    exp_resp = 1'b0; exp_tag = '0; waits = 0; core_done = 1'b0; ref_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!core_req_valid || core_done) begin
        core_req_valid = 1'($urandom); core_req_idx = AW'($urandom_range(0, 7));
      end
      if (!refill_req_valid || ref_done) begin
        refill_req_valid = 1'($urandom); rand_refill();
      end
      @(negedge clk);
      exp_core = core_req_valid && (!refill_req_valid || (STARVE_EN && waits >= STARVE_LIM));
      exp_ref  = refill_req_valid && !exp_core;
      n_checks++;
      if ({core_req_ready, refill_req_ready, mem_ren, mem_wen, flush_busy} !== {exp_core, exp_ref, exp_core, exp_ref, 1'b0}) begin
        n_fail++;
        $display("FAIL rand_grant[%0d]: crdy=%b rrdy=%b ren=%b wen=%b, required %b %b", i,
                 core_req_ready, refill_req_ready, mem_ren, mem_wen, exp_core, exp_ref);
      end
      if (exp_ref) begin
        n_checks++;
        if ({mem_waddr, mem_cs, mem_wdata} !== {refill_req_idx, refill_req_way, {WAYS{refill_req_tag}}}) begin
          n_fail++;
          $display("FAIL rand_write[%0d]: waddr=%0d cs=%b wdata=%h", i, mem_waddr, mem_cs, mem_wdata);
        end
        for (int w = 0; w < WAYS; w++) if (refill_req_way[w]) ref_tag[refill_req_idx][w] = refill_req_tag;
      end
      if (exp_core) begin
        n_checks++;
        if (mem_raddr !== core_req_idx) begin
          n_fail++;
          $display("FAIL rand_raddr[%0d]: raddr=%0d, required %0d", i, mem_raddr, core_req_idx);
        end
      end
      n_checks++;
      if ({core_resp_valid, core_resp_tag} !== {exp_resp, exp_resp ? exp_tag : DW'(0)}) begin
        n_fail++;
        $display("FAIL rand_resp[%0d]: valid=%b tag=%h, required %b %h", i, core_resp_valid, core_resp_tag, exp_resp, exp_tag);
      end
      exp_resp = exp_core;
      if (exp_core) exp_tag = set_tags(core_req_idx);
      if (exp_core) waits = 0;
      else if (core_req_valid && exp_ref) waits++;
      core_done = exp_core; ref_done = exp_ref;
      step();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({core_resp_valid, core_resp_tag} !== {exp_resp, exp_resp ? exp_tag : DW'(0)}) begin
      n_fail++;
      $display("FAIL rand_last_resp: valid=%b tag=%h, required %b %h", core_resp_valid, core_resp_tag, exp_resp, exp_tag);
    end
    step();
  endtask

  task automatic test_flush_reset();
    logic [DW-1:0] exp_tag;
    core_req_valid = 1'b1; core_req_idx = 5;
    @(negedge clk);
    n_checks++;
    if (core_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_flush_grant: rdy=%b, required 1", core_req_ready);
    end
    exp_tag = set_tags(5);
    step();
    flush_req = 1'b1; core_req_idx = 6; refill_req_valid = 1'b1; rand_refill();
    @(negedge clk);
    n_checks++;
    if ({flush_busy, core_req_ready, refill_req_ready, mem_wen, mem_ren, core_resp_valid, core_resp_tag}
        !== {5'b00000, 1'b1, exp_tag}) begin
      n_fail++;
      $display("FAIL flush_req_cycle: busy=%b crdy=%b rrdy=%b wen=%b ren=%b rv=%b tag=%h, required 0 0 0 0 0 1 %h",
               flush_busy, core_req_ready, refill_req_ready, mem_wen, mem_ren, core_resp_valid, core_resp_tag, exp_tag);
    end
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({flush_busy, core_req_ready, refill_req_ready, mem_waddr} !== {3'b100, AW'(i)}) begin
        n_fail++;
        $display("FAIL req_flush[%0d]: busy=%b crdy=%b rrdy=%b waddr=%0d", i, flush_busy, core_req_ready, refill_req_ready, mem_waddr);
      end
      step();
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({flush_busy, core_req_ready, refill_req_ready, core_resp_valid, mem_wen, mem_ren} !== '0) begin
      n_fail++;
      $display("FAIL mid_flush_reset: busy=%b crdy=%b rrdy=%b rv=%b wen=%b ren=%b, required all 0",
               flush_busy, core_req_ready, refill_req_ready, core_resp_valid, mem_wen, mem_ren);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk);
      n_checks++;
      if ({flush_busy, core_req_ready, refill_req_ready, mem_wen, mem_cs, mem_waddr, mem_wdata}
          !== {4'b1001, 4'hF, AW'(i), DW'(0)}) begin
        n_fail++;
        $display("FAIL restart_flush[%0d]: busy=%b crdy=%b rrdy=%b wen=%b cs=%h waddr=%0d", i,
                 flush_busy, core_req_ready, refill_req_ready, mem_wen, mem_cs, mem_waddr);
      end
      step();
    end
    clear_ref();
    refill_req_valid = 1'b0; core_req_idx = 5;
    @(negedge clk);
    n_checks++;
    if ({flush_busy, core_req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL post_flush_grant: busy=%b crdy=%b, required 0 1", flush_busy, core_req_ready);
    end
    step();
    core_req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({core_resp_valid, core_resp_tag} !== {1'b1, set_tags(5)}) begin
      n_fail++;
      $display("FAIL post_flush_read: valid=%b tag=%h, required 1 %h", core_resp_valid, core_resp_tag, set_tags(5));
    end
    step();
  endtask

  initial begin
    idle_inputs();
    core_req_idx = '0; refill_req_idx = '0; refill_req_way = '0; refill_req_tag = '0;
    test_reset();
    test_refill_lookup();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_array_arbiter.md
# tag_array_arbiter

Arbiter and sequencer for a cache tag array built on a synchronous-read memory, with one-cycle read latency and a per-way write mask. It shares the array between three requesters: core tag lookups, refill tag writes, and an internal flush sequencer that zeroes every set after reset or on request. The array is driven as a single-port macro, so at most one of `mem_wen` / `mem_ren` is high in any cycle. It sits between the cache control pipeline and the tag-array instance.

## Interface
- `SETS`, 64: number of sets (array depth); power of two, ≥2.
- `WAYS`, 4: ways per set; equals the array write-mask width.
- `TAG_WIDTH`, 20: tag bits per way.
- `ADDR_WIDTH`, `$clog2(SETS)`: set-index width.
- `STARVE_LIMIT`, 4: wait cycles before the core overrides refill; used only with the configuration macro.

Ports:
- `clk` input 1: sole clock.
- `reset` input 1: synchronous, active-high.
- `core_req_valid` input 1: core lookup request.
- `core_req_ready` output 1: lookup accepted this cycle.
- `core_req_idx` input ADDR_WIDTH: set to read.
- `core_resp_valid` output 1: lookup data valid.
- `core_resp_tag` output WAYS*TAG_WIDTH: tags of all ways; way i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- `refill_req_valid` input 1: tag write request.
- `refill_req_ready` output 1: write accepted this cycle.
- `refill_req_idx` input ADDR_WIDTH: set to write.
- `refill_req_way` input WAYS: one-hot way mask.
- `refill_req_tag` input TAG_WIDTH: tag written into the masked way.
- `flush_req` input 1: single-cycle flush trigger.
- `flush_busy` output 1: flush sequencer active.
- `mem_wen`, `mem_waddr`, `mem_cs[WAYS]`, `mem_wdata[WAYS*TAG_WIDTH]` outputs: array write channel.
- `mem_ren`, `mem_raddr` outputs: array read channel.
- `mem_rdata` input WAYS*TAG_WIDTH: array read data, valid the cycle after `mem_ren`.

## Operation
- **FSM states:** FLUSH and IDLE.
- **Reset:** while `reset` is high, every output is 0 and the next state is FLUSH with the set counter at 0. Asserting reset mid-flush or mid-lookup aborts the operation and restarts the flush from set 0. Any pending `core_resp_valid` is dropped.
- **FLUSH:**
  - Each cycle: `mem_wen=1`, `mem_waddr=counter`, `mem_cs` all ones, `mem_wdata=0`.
  - The counter increments each cycle. After the write to set SETS-1, go to IDLE.
  - `flush_busy=1`; both ready outputs are 0.
  - `flush_req` is ignored while in FLUSH.
- **IDLE, priority order:**
  1. A `flush_req` moves to FLUSH at counter 0. No grant is issued that cycle.
  2. Otherwise, `refill_req_valid` wins: `refill_req_ready=1`, `mem_wen=1`, `mem_waddr=refill_req_idx`, `mem_cs=refill_req_way`, and `refill_req_tag` is replicated into every way slot of `mem_wdata`.
  3. Otherwise, `core_req_valid` wins: `core_req_ready=1`, `mem_ren=1`, `mem_raddr=core_req_idx`.
- **Ready outputs:** ready depends combinationally on the valids and the state. A transfer occurs only when valid and ready are both high in the same cycle. A requester must hold its valid and payload stable until its transfer.
- **Read response:** `core_resp_tag` is `mem_rdata` passed through, gated to 0 when `core_resp_valid=0`.
- **Refill-then-read to the same set:** a refill write in cycle N followed by a core read in N+1 returns the new tag; no bypass is needed.

## Timing
- **Core read:** accepted in cycle N; `core_resp_valid` is a registered pulse in N+1. Back-to-back reads sustain one per cycle.
- **Refill write:** takes effect at the clock edge ending the grant cycle. The write latency seen by a later read is one cycle.
- **Flush after reset:** occupies exactly SETS cycles, starting in the first cycle after reset deasserts. `flush_busy` falls in the cycle after the write to set SETS-1.
- **Flush on request:** `flush_req` in IDLE at cycle N gives `flush_busy=1` from N+1 through N+SETS. A lookup response already in flight still appears in N+1.

## Configuration
- **`TAG_ARB_STARVE_EN` defined:**
  - A counter counts consecutive IDLE cycles in which `core_req_valid=1` but the core loses to refill.
  - When the count reaches STARVE_LIMIT, the next IDLE grant goes to the core regardless of refill.
  - The counter clears on any core grant, on reset, and on entry to FLUSH.
- **Undefined:** strict refill-over-core priority; no counter logic is present.

## Test plan
- **Reset-time flush.** Stimulus: SETS=64; release reset. Required: `flush_busy=1` for 64 cycles; `mem_waddr` runs 0..63 with `mem_cs=4'b1111` and `mem_wdata=0`; both readies stay 0 throughout.
- **Lookup after refill.** Stimulus: refill idx=5, way=4'b0100, tag=0xABCDE; core read of idx 5 in the next cycle. Required: `core_resp_valid` one cycle later; way 2 reads 0xABCDE, all other ways read 0.
- **Simultaneous requests.** Stimulus: both valids held high for 3 cycles. Required, macro off: refill granted every cycle and the core never granted. Required, macro on with STARVE_LIMIT=2: refill, refill, then core.
- **Back-to-back reads.** Stimulus: core reads idx 0,1,2 on consecutive cycles. Required: three consecutive `core_resp_valid` pulses carrying the set 0,1,2 contents in order.
- **Flush on request, then reset.** Stimulus: `flush_req` in IDLE; assert reset at flush counter 10. Required: the flush restarts at set 0 one cycle after reset deasserts; no ready output is asserted until 64 flush writes complete.
